// File: rtl/mac_sequencer.sv
// mac_sequencer
// -------------
// Control-side driver for the 8-bit signed MAC unit. For each of NEURONS
// output neurons it reads a VEC_LEN-element image vector and weight row from
// single-port synchronous RAMs (1-cycle read latency), streams registered
// operand pairs to the MAC with acc_en/relu_en/clear strobes aligned to the
// MAC's internal pipeline, then captures the 32-bit accumulator, requantizes
// it (arithmetic shift right by SHIFT, saturate to signed 8 bit) and emits it
// on a valid/ready stream.
//
// Configuration macro: MAC_SEQ_RELU_EN
//   defined   : RELU state present, mac_relu_en_o pulses once per neuron.
//   undefined : RELU state omitted, mac_relu_en_o tied to 0 (signed logits).
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   start_i                begin a layer pass (sampled only in IDLE)
//   busy_o / done_o        pass in progress / one-cycle completion pulse
//   img_rd_o, img_addr_o   image RAM read strobe and address
//   img_data_i             signed image byte (cycle after the read)
//   w_rd_o, w_addr_o       weight RAM read strobe and address
//   w_data_i               signed weight byte (cycle after the read)
//   mac_image_o/weight_o   registered operands to the MAC
//   mac_acc_en_o           accumulate strobe (read strobe delayed 4 cycles)
//   mac_relu_en_o          ReLU strobe (macro builds only)
//   mac_clear_o            accumulator clear strobe
//   mac_result_i           MAC accumulator value
//   out_valid_o/ready_i    result stream handshake
//   out_data_o, out_idx_o  requantized result and its neuron index
//   dbg_state_o            current FSM state encoding, for observation
//
// Handshake: a result transfers in a cycle where out_valid_o and out_ready_i
// are both 1. Once out_valid_o rises it stays high, with out_data_o and
// out_idx_o stable, until that transfer cycle; valid never depends on ready.
module mac_sequencer #(
  parameter int VEC_LEN = 784,
  parameter int NEURONS = 10,
  parameter int IMG_AW  = 10,
  parameter int W_AW    = 13,
  parameter int SHIFT   = 7,
  localparam int IDX_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              img_rd_o,
  output logic [IMG_AW-1:0] img_addr_o,
  input  logic [7:0]        img_data_i,
  output logic              w_rd_o,
  output logic [W_AW-1:0]   w_addr_o,
  input  logic [7:0]        w_data_i,
  output logic [7:0]        mac_image_o,
  output logic [7:0]        mac_weight_o,
  output logic              mac_acc_en_o,
  output logic              mac_relu_en_o,
  output logic              mac_clear_o,
  input  logic [31:0]       mac_result_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [7:0]        out_data_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FETCH   = 3'd2,
    S_DRAIN   = 3'd3,
    S_CAPTURE = 3'd4,
    S_OUT     = 3'd5
`ifdef MAC_SEQ_RELU_EN
    , S_RELU  = 3'd6
`endif
  } state_e;

  localparam logic [IMG_AW-1:0] K_LAST = IMG_AW'(VEC_LEN - 1);
  localparam logic [IDX_W-1:0]  N_LAST = IDX_W'(NEURONS - 1);

  state_e              state_q, state_d;
  logic [IMG_AW-1:0]   k_q, k_d;          // element index within the row
  logic [1:0]          drain_q, drain_d;  // DRAIN cycle count
  logic [IDX_W-1:0]    n_q, n_d;          // neuron index
  logic [W_AW-1:0]     w_q, w_d;          // weight address, runs across neurons
  logic [3:0]          vld_q, vld_d;      // read strobe delay line
  logic [7:0]          img_q, img_d;
  logic [7:0]          wgt_q, wgt_d;
  logic [7:0]          out_data_q, out_data_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic                done_q, done_d;
  logic                fetch;
  logic signed [31:0]  shifted;
  logic [7:0]          sat;

  // Requantization of the live accumulator value; only latched in CAPTURE.
  always_comb begin
    shifted = $signed(mac_result_i) >>> SHIFT;
    if (shifted > 32'sd127)       sat = 8'h7F;
    else if (shifted < -32'sd128) sat = 8'h80;
    else                          sat = shifted[7:0];
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    drain_d    = drain_q;
    n_d        = n_q;
    w_d        = w_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    done_d     = 1'b0;
    fetch      = 1'b0;
    case (state_q)
      S_IDLE: begin
        k_d     = '0;
        drain_d = '0;
        n_d     = '0;
        w_d     = '0;
        if (start_i) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        k_d     = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        fetch = 1'b1;
        w_d   = w_q + W_AW'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + IMG_AW'(1);
        end
      end
      S_DRAIN: begin
        // Four cycles let the last read travel through RAM, operand and
        // product registers so its acc_en has been issued before leaving.
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
`ifdef MAC_SEQ_RELU_EN
          state_d = S_RELU;
`else
          state_d = S_CAPTURE;
`endif
        end
      end
`ifdef MAC_SEQ_RELU_EN
      S_RELU: state_d = S_CAPTURE;
`endif
      S_CAPTURE: begin
        out_data_d = sat;
        out_idx_d  = n_q;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready_i) begin
          if (n_q == N_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            n_d     = n_q + IDX_W'(1);
            state_d = S_CLEAR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand pipe: vld_q[0] marks the cycle RAM data is present, so the
  // operand registers pick up data only then and hold 0 otherwise.
  always_comb begin
    vld_d = {vld_q[2:0], fetch};
    img_d = vld_q[0] ? img_data_i : 8'h00;
    wgt_d = vld_q[0] ? w_data_i   : 8'h00;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      drain_q    <= '0;
      n_q        <= '0;
      w_q        <= '0;
      vld_q      <= '0;
      img_q      <= '0;
      wgt_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      n_q        <= n_d;
      w_q        <= w_d;
      vld_q      <= vld_d;
      img_q      <= img_d;
      wgt_q      <= wgt_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign img_rd_o     = fetch;
  assign w_rd_o       = fetch;
  assign img_addr_o   = fetch ? k_q : '0;
  assign w_addr_o     = fetch ? w_q : '0;
  assign mac_image_o  = img_q;
  assign mac_weight_o = wgt_q;
  assign mac_acc_en_o = vld_q[3];
  assign mac_clear_o  = (state_q == S_CLEAR);
`ifdef MAC_SEQ_RELU_EN
  assign mac_relu_en_o = (state_q == S_RELU);
`else
  assign mac_relu_en_o = 1'b0;
`endif
  assign out_valid_o  = (state_q == S_OUT);
  assign out_data_o   = out_data_q;
  assign out_idx_o    = out_idx_q;
  assign dbg_state_o  = state_q;

endmodule
